// File: rtl/l1_instr_pkg.sv
// rtl/l1_instr_pkg.sv - shared types, default geometry and tree-PLRU helpers for the L1 instruction cache
package l1_instr_pkg;

    typedef enum logic {IDLE, FLUSH} state_e;

    localparam int DEF_BLOCK_SIZE = 128;
    localparam int DEF_TAG_SIZE   = 9;
    localparam int DEF_IDX_SIZE   = 6;
    localparam int DEF_WAYS       = 2;
    localparam int DEF_NEXT_W     = 16;

    localparam int NUM_SETS = 2 ** DEF_IDX_SIZE;
    localparam int WAY_W    = $clog2(DEF_WAYS);
    localparam int PLRU_W   = DEF_WAYS - 1;

    // Trees are handled at the 8-way size; a node bit of 1 means the victim lies in the upper half.
    function automatic logic [2:0] plru_victim(input logic [6:0] bits, input int levels);
        logic [2:0] way;
        logic [2:0] node;
        logic       dir;
        way  = '0;
        node = '0;
        dir  = 1'b0;
        for (int l = 0; l < 3; l++) begin
            if (l < levels) begin
                dir  = bits[node];
                way  = {way[1:0], dir};
                node = {node[1:0], 1'b0} + 3'd1 + {2'b00, dir};
            end
        end
        return way;
    endfunction

    function automatic logic [6:0] plru_touch(input logic [6:0] bits, input logic [2:0] way, input int levels);
        logic [6:0] res;
        logic [2:0] node;
        logic [2:0] w;
        logic       dir;
        res  = bits;
        node = '0;
        dir  = 1'b0;
        w    = way << (3 - levels);
        for (int l = 0; l < 3; l++) begin
            if (l < levels) begin
                dir       = w[2];
                res[node] = ~dir;
                node      = {node[1:0], 1'b0} + 3'd1 + {2'b00, dir};
                w         = w << 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/cache_set_assoc_l1_instr_if.sv
// rtl/cache_set_assoc_l1_instr_if.sv - lookup, response and refill bundle of the L1 instruction cache
interface cache_set_assoc_l1_instr_if #(
    parameter int BLOCK_SIZE = 128,
    parameter int TAG_SIZE   = 9,
    parameter int IDX_SIZE   = 6,
    parameter int WAYS       = 2,
    parameter int NEXT_W     = 16
) ();
    logic                         req_valid_i;
    logic [TAG_SIZE+IDX_SIZE-1:0] req_addr_i;
    logic                         req_ready_o;
    logic                         rsp_valid_o;
    logic                         rsp_hit_o;
    logic [BLOCK_SIZE-1:0]        rsp_block_o;
    logic                         rsp_next_hit_o;
    logic [NEXT_W-1:0]            rsp_next_o;
    logic                         refill_valid_i;
    logic [TAG_SIZE+IDX_SIZE-1:0] refill_addr_i;
    logic [BLOCK_SIZE-1:0]        refill_block_i;
    logic                         refill_ready_o;
    logic [$clog2(WAYS)-1:0]      victim_way_o;

    modport slave (
        input  req_valid_i, req_addr_i, refill_valid_i, refill_addr_i, refill_block_i,
        output req_ready_o, rsp_valid_o, rsp_hit_o, rsp_block_o, rsp_next_hit_o, rsp_next_o,
               refill_ready_o, victim_way_o
    );

    modport master (
        output req_valid_i, req_addr_i, refill_valid_i, refill_addr_i, refill_block_i,
        input  req_ready_o, rsp_valid_o, rsp_hit_o, rsp_block_o, rsp_next_hit_o, rsp_next_o,
               refill_ready_o, victim_way_o
    );
endinterface

// File: rtl/plru_tree.sv
// rtl/plru_tree.sv - combinational tree-PLRU victim pick and MRU update for one set
module plru_tree
    import l1_instr_pkg::*;
#(
    parameter int WAYS = DEF_WAYS
) (
    input  logic [WAYS-2:0]         bits_i,
    input  logic [$clog2(WAYS)-1:0] touch_way_i,
    output logic [$clog2(WAYS)-1:0] victim_o,
    output logic [WAYS-2:0]         bits_o
);
    localparam int LVL = $clog2(WAYS);

    logic [6:0] bits_ext;
    logic [2:0] way_ext;
    logic [2:0] victim_ext;
    logic [6:0] touched;
    logic       width_pad_unused;

    assign bits_ext   = 7'(bits_i);
    assign way_ext    = 3'(touch_way_i);
    assign victim_ext = plru_victim(bits_ext, LVL);
    assign touched    = plru_touch(bits_ext, way_ext, LVL);

    assign victim_o = victim_ext[LVL-1:0];
    assign bits_o   = touched[WAYS-2:0];

    assign width_pad_unused = ^{victim_ext, touched};
endmodule

// File: rtl/cache_set_assoc_l1_instr.sv
// rtl/cache_set_assoc_l1_instr.sv - N-way set-associative L1 instruction cache array with next-line probe and flush engine
module cache_set_assoc_l1_instr
    import l1_instr_pkg::*;
#(
    parameter int BLOCK_SIZE = DEF_BLOCK_SIZE,
    parameter int TAG_SIZE   = DEF_TAG_SIZE,
    parameter int IDX_SIZE   = DEF_IDX_SIZE,
    parameter int WAYS       = DEF_WAYS,
    parameter int NEXT_W     = DEF_NEXT_W
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        flush_i,
    output logic                        flush_busy_o,
    cache_set_assoc_l1_instr_if.slave   bus
);
    localparam int SETS = 2 ** IDX_SIZE;
    localparam int WW   = $clog2(WAYS);
    localparam int PW   = WAYS - 1;

    state_e              state_q, state_d;
    logic [IDX_SIZE-1:0] flush_cnt_q, flush_cnt_d;
    logic                ready;

    logic [WAYS-1:0]       valid_q [SETS];
    logic [PW-1:0]         plru_q  [SETS];
    logic [TAG_SIZE-1:0]   tag_q   [SETS][WAYS];
    logic [BLOCK_SIZE-1:0] data_q  [SETS][WAYS];

    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_hit_q, rsp_hit_d;
    logic [BLOCK_SIZE-1:0] rsp_block_q, rsp_block_d;
    logic                  rsp_next_hit_q, rsp_next_hit_d;
    logic [NEXT_W-1:0]     rsp_next_q, rsp_next_d;

    logic [TAG_SIZE-1:0] req_tag, nxt_tag, ref_tag;
    logic [IDX_SIZE-1:0] req_idx, nxt_idx, ref_idx;
    logic                req_fire, ref_fire;

    logic                  hit, nxt_hit;
    logic [WW-1:0]         hit_way;
    logic [BLOCK_SIZE-1:0] hit_block;
    logic [NEXT_W-1:0]     nxt_bits;

    logic          ref_match, ref_inv;
    logic [WW-1:0] ref_match_way, ref_inv_way, ref_plru_victim, victim;
    logic [PW-1:0] lk_plru_new, ref_plru_new;
    logic [WW-1:0] lk_victim_unused;

    assign {req_tag, req_idx} = bus.req_addr_i;
    assign {ref_tag, ref_idx} = bus.refill_addr_i;
    assign nxt_idx  = req_idx + 1'b1;
    assign nxt_tag  = req_tag + TAG_SIZE'(nxt_idx == '0);
    assign req_fire = bus.req_valid_i & ready;
    assign ref_fire = bus.refill_valid_i & ready;

    always_comb begin
        state_d      = state_q;
        flush_cnt_d  = flush_cnt_q;
        ready        = 1'b0;
        flush_busy_o = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (flush_i) begin
                    state_d     = FLUSH;
                    flush_cnt_d = '0;
                end
            end
            FLUSH: begin
                flush_busy_o = 1'b1;
                flush_cnt_d  = flush_cnt_q + 1'b1;
                if (flush_cnt_q == IDX_SIZE'(SETS - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Lookup is resolved against current contents and registered, so a same-edge refill is not seen.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        hit_block = '0;
        nxt_hit   = 1'b0;
        nxt_bits  = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
                hit       = 1'b1;
                hit_way   = WW'(w);
                hit_block = data_q[req_idx][w];
            end
            if (valid_q[nxt_idx][w] && tag_q[nxt_idx][w] == nxt_tag) begin
                nxt_hit  = 1'b1;
                nxt_bits = data_q[nxt_idx][w][NEXT_W-1:0];
            end
        end
    end

    always_comb begin
        ref_match     = 1'b0;
        ref_match_way = '0;
        ref_inv       = 1'b0;
        ref_inv_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[ref_idx][w] && tag_q[ref_idx][w] == ref_tag) begin
                ref_match     = 1'b1;
                ref_match_way = WW'(w);
            end
            if (!valid_q[ref_idx][w]) begin
                ref_inv     = 1'b1;
                ref_inv_way = WW'(w);
            end
        end
        victim = ref_match ? ref_match_way : (ref_inv ? ref_inv_way : ref_plru_victim);
    end

    always_comb begin
        rsp_valid_d    = req_fire;
        rsp_hit_d      = req_fire & hit;
        rsp_block_d    = req_fire ? hit_block : '0;
        rsp_next_hit_d = req_fire & nxt_hit;
        rsp_next_d     = req_fire ? nxt_bits : '0;
    end

    plru_tree #(.WAYS(WAYS)) u_plru_lookup (
        .bits_i      (plru_q[req_idx]),
        .touch_way_i (hit_way),
        .victim_o    (lk_victim_unused),
        .bits_o      (lk_plru_new)
    );

    plru_tree #(.WAYS(WAYS)) u_plru_refill (
        .bits_i      (plru_q[ref_idx]),
        .touch_way_i (victim),
        .victim_o    (ref_plru_victim),
        .bits_o      (ref_plru_new)
    );

    // The refill PLRU write comes last so it wins over a hit update to the same set.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            flush_cnt_q    <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_hit_q      <= 1'b0;
            rsp_block_q    <= '0;
            rsp_next_hit_q <= 1'b0;
            rsp_next_q     <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            state_q        <= state_d;
            flush_cnt_q    <= flush_cnt_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_hit_q      <= rsp_hit_d;
            rsp_block_q    <= rsp_block_d;
            rsp_next_hit_q <= rsp_next_hit_d;
            rsp_next_q     <= rsp_next_d;
            if (state_q == FLUSH) begin
                valid_q[flush_cnt_q] <= '0;
                plru_q[flush_cnt_q]  <= '0;
            end
            if (req_fire && hit) plru_q[req_idx] <= lk_plru_new;
            if (ref_fire) begin
                valid_q[ref_idx][victim] <= 1'b1;
                plru_q[ref_idx]          <= ref_plru_new;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (ref_fire) begin
            tag_q[ref_idx][victim]  <= ref_tag;
            data_q[ref_idx][victim] <= bus.refill_block_i;
        end
    end

    assign bus.req_ready_o    = ready;
    assign bus.refill_ready_o = ready;
    assign bus.victim_way_o   = victim;
    assign bus.rsp_valid_o    = rsp_valid_q;
    assign bus.rsp_hit_o      = rsp_hit_q;
    assign bus.rsp_block_o    = rsp_block_q;
    assign bus.rsp_next_hit_o = rsp_next_hit_q;
    assign bus.rsp_next_o     = rsp_next_q;
endmodule

// File: tb/tb_cache_set_assoc_l1_instr.sv
// tb/tb_cache_set_assoc_l1_instr.sv - scoreboard bench for the set-associative L1 instruction cache
module tb_cache_set_assoc_l1_instr;
    import l1_instr_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    logic flush_busy;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    cache_set_assoc_l1_instr_if #(
        .BLOCK_SIZE(DEF_BLOCK_SIZE), .TAG_SIZE(DEF_TAG_SIZE), .IDX_SIZE(DEF_IDX_SIZE),
        .WAYS(DEF_WAYS), .NEXT_W(DEF_NEXT_W)
    ) bus ();

    cache_set_assoc_l1_instr #(
        .BLOCK_SIZE(DEF_BLOCK_SIZE), .TAG_SIZE(DEF_TAG_SIZE), .IDX_SIZE(DEF_IDX_SIZE),
        .WAYS(DEF_WAYS), .NEXT_W(DEF_NEXT_W)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .flush_i      (flush),
        .flush_busy_o (flush_busy),
        .bus          (bus)
    );

    typedef struct {
        string        name;
        logic         hit;
        logic [127:0] blk;
        logic         nhit;
        logic [15:0]  nxt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    // Reference model: two ways per set, mp holds the least recently used way.
    logic         mv [64][2];
    logic [8:0]   mt [64][2];
    logic [127:0] md [64][2];
    int           mp [64];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [14:0] mk(input logic [8:0] t, input logic [5:0] i);
        return {t, i};
    endfunction

    function automatic int m_find(input logic [5:0] s, input logic [8:0] t);
        for (int w = 0; w < 2; w++) if (mv[s][w] && mt[s][w] == t) return w;
        return -1;
    endfunction

    function automatic int m_victim(input logic [5:0] s, input logic [8:0] t);
        int w;
        w = m_find(s, t);
        if (w >= 0) return w;
        if (!mv[s][0]) return 0;
        if (!mv[s][1]) return 1;
        return mp[s];
    endfunction

    task automatic m_clear();
        for (int s = 0; s < 64; s++) begin
            mv[s][0] = 1'b0;
            mv[s][1] = 1'b0;
            mp[s]    = 0;
        end
    endtask

    task automatic cycle_op(input string name, input bit lk, input logic [14:0] la,
                            input bit rf, input logic [14:0] ra, input logic [127:0] rd);
        exp_t       e;
        int         w, nw, vw;
        logic [5:0] ns;
        logic [8:0] nt;
        for (int i = 0; i < 200 && !(bus.req_ready_o && bus.refill_ready_o); i++) begin
            @(posedge clk);
            #1;
        end
        check({name, "_ready"}, 128'(bus.req_ready_o & bus.refill_ready_o), 128'(1));
        bus.req_valid_i    = lk;
        bus.req_addr_i     = la;
        bus.refill_valid_i = rf;
        bus.refill_addr_i  = ra;
        bus.refill_block_i = rd;
        if (lk) begin
            w      = m_find(la[5:0], la[14:6]);
            ns     = la[5:0] + 6'd1;
            nt     = (la[5:0] == 6'd63) ? la[14:6] + 9'd1 : la[14:6];
            nw     = m_find(ns, nt);
            e.name = name;
            e.hit  = (w >= 0);
            e.blk  = (w >= 0) ? md[la[5:0]][w] : '0;
            e.nhit = (nw >= 0);
            e.nxt  = (nw >= 0) ? md[ns][nw][15:0] : '0;
            exp_q.push_back(e);
        end
        vw = 0;
        if (rf) begin
            vw = m_victim(ra[5:0], ra[14:6]);
            #1;
            check({name, "_victim"}, 128'(bus.victim_way_o), 128'(vw));
        end
        @(posedge clk);
        if (lk) begin
            w = m_find(la[5:0], la[14:6]);
            if (w >= 0) mp[la[5:0]] = 1 - w;
        end
        if (rf) begin
            mv[ra[5:0]][vw] = 1'b1;
            mt[ra[5:0]][vw] = ra[14:6];
            md[ra[5:0]][vw] = rd;
            mp[ra[5:0]]     = 1 - vw;
        end
        #1;
        bus.req_valid_i    = 1'b0;
        bus.refill_valid_i = 1'b0;
    endtask

    task automatic lk_op(input string name, input logic [14:0] a);
        cycle_op(name, 1'b1, a, 1'b0, '0, '0);
    endtask

    task automatic rf_op(input string name, input logic [14:0] a, input logic [127:0] d);
        cycle_op(name, 1'b0, '0, 1'b1, a, d);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.rsp_valid_o) begin
                if (exp_q.size() == 0) begin
                    check("rsp_spurious", 128'(bus.rsp_valid_o), 128'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    check({mon_e.name, "_hit"}, 128'(bus.rsp_hit_o), 128'(mon_e.hit));
                    check({mon_e.name, "_block"}, bus.rsp_block_o, mon_e.blk);
                    check({mon_e.name, "_next_hit"}, 128'(bus.rsp_next_hit_o), 128'(mon_e.nhit));
                    check({mon_e.name, "_next"}, 128'(bus.rsp_next_o), 128'(mon_e.nxt));
                end
            end else begin
                check("rsp_idle_zero", {bus.rsp_block_o[125:0], bus.rsp_hit_o, bus.rsp_next_hit_o} |
                      128'(bus.rsp_next_o), 128'(0));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: sim time %0t, required finish before 2000000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] da5, d2, d3, d4, d5, d6, d7;
        int nb, bad;
        da5 = {16{8'hA5}};
        d2  = {4{32'h1234_0002}};
        d3  = {4{32'h0BAD_0003}};
        d4  = {4{32'hCAFE_0004}};
        d5  = {4{32'hBEEF_5A5A}};
        d6  = {4{32'h6666_0006}};
        d7  = {4{32'h7777_0007}};
        m_clear();
        rst_n = 1'b0;
        flush = 1'b0;
        bus.req_valid_i    = 1'b0;
        bus.req_addr_i     = '0;
        bus.refill_valid_i = 1'b0;
        bus.refill_addr_i  = '0;
        bus.refill_block_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rsp_valid", 128'(bus.rsp_valid_o), 128'(0));
        check("rst_flush_busy", 128'(flush_busy), 128'(0));
        check("rst_req_ready", 128'(bus.req_ready_o), 128'(1));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        lk_op("cold_miss", mk(9'h005, 6'd3));
        rf_op("rf_5_3", mk(9'h005, 6'd3), da5);
        lk_op("hit_5_3", mk(9'h005, 6'd3));
        rf_op("rf_6_3", mk(9'h006, 6'd3), d2);
        rf_op("rf_7_3", mk(9'h007, 6'd3), d3);
        lk_op("evicted_5_3", mk(9'h005, 6'd3));
        lk_op("hit_6_3", mk(9'h006, 6'd3));
        lk_op("hit_7_3", mk(9'h007, 6'd3));
        rf_op("rewrite_7_3", mk(9'h007, 6'd3), d6);
        lk_op("hit_new_7_3", mk(9'h007, 6'd3));
        lk_op("next_only_6_2", mk(9'h006, 6'd2));

        rf_op("rf_5_4", mk(9'h005, 6'd4), da5);
        rf_op("rf_6_4", mk(9'h006, 6'd4), d2);
        lk_op("touch_5_4", mk(9'h005, 6'd4));
        rf_op("rf_7_4", mk(9'h007, 6'd4), d3);
        lk_op("evicted_6_4", mk(9'h006, 6'd4));
        lk_op("kept_5_4", mk(9'h005, 6'd4));

        rf_op("rf_10_63", mk(9'h010, 6'd63), d4);
        rf_op("rf_11_0", mk(9'h011, 6'd0), d5);
        lk_op("wrap_10_63", mk(9'h010, 6'd63));

        for (int s = 10; s < 14; s++) rf_op("fill", mk(9'h020, 6'(s)), d7 ^ 128'(s));
        flush = 1'b1;
        lk_op("flush_same_cycle", mk(9'h020, 6'd10));
        flush = 1'b0;
        nb  = 0;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!flush_busy) break;
            nb++;
            if (bus.req_ready_o || bus.refill_ready_o) bad++;
        end
        check("flush_len", 128'(nb), 128'(NUM_SETS));
        check("flush_ready_low", 128'(bad), 128'(0));
        m_clear();
        for (int s = 10; s < 14; s++) lk_op("post_flush", mk(9'h020, 6'(s)));
        lk_op("post_flush_7_3", mk(9'h007, 6'd3));

        rf_op("rf_30_20", mk(9'h030, 6'd20), d6);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("busy_before_rst", 128'(flush_busy), 128'(1));
        rst_n = 1'b0;
        #1;
        check("rst_flush_busy_mid", 128'(flush_busy), 128'(0));
        check("rst_ready_mid", 128'(bus.req_ready_o), 128'(1));
        #2;
        rst_n = 1'b1;
        m_clear();
        @(posedge clk);
        #1;
        lk_op("after_rst_30_20", mk(9'h030, 6'd20));
        lk_op("after_rst_10_63", mk(9'h010, 6'd63));

        cycle_op("same_cycle", 1'b1, mk(9'h040, 6'd7), 1'b1, mk(9'h040, 6'd7), d7);
        lk_op("after_same_cycle", mk(9'h040, 6'd7));

        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", 128'(exp_q.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cache_set_assoc_l1_instr.md
Name: cache_set_assoc_l1_instr

Overview:
Parametrised N-way set-associative L1 instruction cache array. It is the successor to the direct-mapped L1 instruction set.
- Holds data, tag and valid bits for every way, with tree pseudo-LRU replacement per set.
- Provides a 1-cycle registered lookup that also probes the next sequential line, for fetches that straddle a line.
- Provides a refill write port with automatic victim selection, and a multi-cycle flush engine.
- Sits between the fetch unit and the L1 miss handler / L2 interface.

Parameters:
BLOCK_SIZE, 128, line width in bits
TAG_SIZE, 9, tag bits
IDX_SIZE, 6, index bits; NUM_SETS = 2**IDX_SIZE
WAYS, 2, associativity; legal values 2, 4, 8
NEXT_W, 16, width of the low slice returned from the next sequential line

Ports:
clk_i  in  1  clock; all state updates on the rising edge
rst_ni  in  1  asynchronous, active-low reset
flush_i  in  1  request invalidation of all lines (sampled only in IDLE)
flush_busy_o  out  1  high while in FLUSH
req_valid_i  in  1  lookup request
req_addr_i  in  TAG_SIZE+IDX_SIZE  {tag, index}
req_ready_o  out  1  lookup accepted when req_valid_i & req_ready_o
rsp_valid_o  out  1  response strobe, one cycle
rsp_hit_o  out  1  line present in some way
rsp_block_o  out  BLOCK_SIZE  hit way's line; 0 on miss
rsp_next_hit_o  out  1  next sequential line present
rsp_next_o  out  NEXT_W  next line bits [NEXT_W-1:0]; 0 on next-miss
refill_valid_i  in  1  refill write request
refill_addr_i  in  TAG_SIZE+IDX_SIZE  {tag, index} of refilled line
refill_block_i  in  BLOCK_SIZE  line data
refill_ready_o  out  1  refill accepted when refill_valid_i & refill_ready_o
victim_way_o  out  $clog2(WAYS)  way chosen for the current refill (combinational, valid when refill_valid_i)

Behaviour:
- Reset (rst_ni=0, asynchronous):
  - All valid bits 0; all PLRU bits 0.
  - State IDLE; flush counter 0.
  - rsp_* outputs 0; flush_busy_o 0.
  - Data and tag arrays are not reset.
  - Reset asserted mid-flush or mid-lookup aborts the operation; no response is emitted.
- FSM states IDLE and FLUSH.
  - IDLE: req_ready_o=1, refill_ready_o=1.
  - IDLE with flush_i=1 -> FLUSH, counter=0. A lookup or refill presented in that same cycle is still accepted and completes.
  - FLUSH: each cycle, clear the valid bits and PLRU bits of set[counter], then increment the counter. After set NUM_SETS-1 is cleared -> IDLE. FLUSH lasts exactly NUM_SETS cycles.
  - During FLUSH: req_ready_o=0, refill_ready_o=0, flush_busy_o=1; flush_i is ignored.
- Lookup (latency 1):
  - An accepted request at edge N gives rsp_valid_o=1 during cycle N+1.
  - Hit = valid[w] & tag[w]==req tag for some w. At most one way may match.
  - rsp_valid_o=0 in cycles with no accepted request; rsp_* data outputs are 0 then.
- Next-line probe:
  - next index = index+1, wrapping to 0 after NUM_SETS-1.
  - On wrap, next tag = tag+1, modulo 2**TAG_SIZE.
  - Same hit rule as the main lookup; returns the hit way's bits [NEXT_W-1:0].
- PLRU:
  - Tree of WAYS-1 bits per set. On a main hit, mark the hit way MRU at the response edge.
  - The next-line probe does not update PLRU.
- Refill:
  - Way selection: if the tag already matches a valid way, rewrite that way. Else pick the lowest-numbered invalid way. Else pick the PLRU victim.
  - At the accept edge: write data and tag, set valid, mark the written way MRU.
- Simultaneous events:
  - Lookup and refill of the same set in the same cycle: the lookup observes pre-write contents (read-before-write).
  - Refill PLRU update and hit PLRU update to the same set on the same edge: the refill update is applied last and wins.
  - A hit whose line is evicted by a refill on the response edge still reports the old data.

Decomposition:
- Package l1_instr_pkg holds:
  - the state enum {IDLE, FLUSH};
  - the localparams NUM_SETS, WAY_W = $clog2(WAYS), PLRU_W = WAYS-1;
  - functions plru_victim(bits) and plru_touch(bits, way).
- One sub-module, plru_tree: combinational victim/update logic for one set. It is instantiated once on the lookup path and once on the refill path.
- Data, tag and valid arrays are per-way flop arrays inside the top module.

Test Plan:
- Reset, then lookup {tag 9'h005, idx 6'd3} -> rsp_valid_o=1 one cycle later, rsp_hit_o=0, rsp_block_o=0.
- Refill {9'h005, 3} with data 128'hA5..A5, then lookup the same address -> hit, block A5..A5. Refill {9'h006, 3} -> way 1; refill {9'h007, 3} -> evicts way 0 (LRU).
- Same setup, but lookup {9'h005, 3} before the third refill -> way 0 becomes MRU, and refill {9'h007, 3} evicts way 1.
- Refill {9'h010, 63} and {9'h011, 0}, then lookup {9'h010, 63} -> main hit, rsp_next_hit_o=1 (wrap with tag+1), rsp_next_o = refill data [15:0].
- Fill 4 sets, assert flush_i -> flush_busy_o high for exactly 64 cycles with req_ready_o=0; afterwards all previously filled addresses miss.
- Assert rst_ni low in flush cycle 10 -> state IDLE, flush_busy_o=0 immediately, all lines miss. Refill and lookup of the same set in one cycle -> miss reported, and the next lookup hits.
